lc3b_mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter for the pipelined LC-3b core. It shares the single physical-memory line port between the instruction cache (fetch misses) and the data cache (LDR/STR misses and write-backs). It grants the port round-robin when both caches request in the same cycle and registers address, data and command toward memory for the whole transaction. It keeps saturating per-requester grant counters for performance reporting.

---
 rtl/lc3b_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_lc3b_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter
// Shares the single physical-memory line port between the I-cache and the
// D-cache of the pipelined LC-3b core. Simultaneous requests are granted
// round-robin; the command, address and write line toward memory are held in
// registers for the whole transaction. Saturating per-requester grant counters
// are kept for performance reporting.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   i_mem_*             I-cache line read port (request held until i_mem_resp)
//   d_mem_*             D-cache line read/write port (held until d_mem_resp)
//   pmem_*              physical memory line port (commands are registered)
//   i_grant_cnt         number of I-cache grants, saturating at all-ones
//   d_grant_cnt         number of D-cache grants, saturating at all-ones
module lc3b_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_mem_read,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  output logic [LINE_WIDTH-1:0] i_mem_rdata,
  output logic                  i_mem_resp,
  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic [LINE_WIDTH-1:0] d_mem_wdata,
  output logic [LINE_WIDTH-1:0] d_mem_rdata,
  output logic                  d_mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic [CNT_WIDTH-1:0]  i_grant_cnt,
  output logic [CNT_WIDTH-1:0]  d_grant_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    TURN    = 2'd3
  } state_e;

  // Encoding of the last_grant register.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    pmem_read_q, pmem_read_d;
  logic                    pmem_write_q, pmem_write_d;
  logic [ADDR_WIDTH-1:0]   pmem_address_q, pmem_address_d;
  logic [LINE_WIDTH-1:0]   pmem_wdata_q, pmem_wdata_d;
  logic [CNT_WIDTH-1:0]    i_grant_cnt_q, i_grant_cnt_d;
  logic [CNT_WIDTH-1:0]    d_grant_cnt_q, d_grant_cnt_d;
  logic                    i_req_s;
  logic                    d_req_s;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  assign i_req_s = i_mem_read;
  assign d_req_s = d_mem_read | d_mem_write;

  // Next-state logic: arbitration in IDLE, hold during service, one TURN cycle.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    i_grant_cnt_d  = i_grant_cnt_q;
    d_grant_cnt_d  = d_grant_cnt_q;
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time is served.
        if (i_req_s && (!d_req_s || (last_grant_q == GRANT_D))) begin
          state_d        = SERVE_I;
          last_grant_d   = GRANT_I;
          pmem_read_d    = 1'b1;
          pmem_write_d   = 1'b0;
          pmem_address_d = i_mem_address;
          i_grant_cnt_d  = sat_inc(i_grant_cnt_q);
        end else if (d_req_s) begin
          // Write wins if the (illegal) read+write combination is presented.
          state_d        = SERVE_D;
          last_grant_d   = GRANT_D;
          pmem_read_d    = ~d_mem_write;
          pmem_write_d   = d_mem_write;
          pmem_address_d = d_mem_address;
          pmem_wdata_d   = d_mem_wdata;
          d_grant_cnt_d  = sat_inc(d_grant_cnt_q);
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d      = TURN;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      TURN: begin
        // Gives the finished owner a cycle to drop its request.
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      last_grant_q   <= GRANT_D;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= {ADDR_WIDTH{1'b0}};
      pmem_wdata_q   <= {LINE_WIDTH{1'b0}};
      i_grant_cnt_q  <= {CNT_WIDTH{1'b0}};
      d_grant_cnt_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      i_grant_cnt_q  <= i_grant_cnt_d;
      d_grant_cnt_q  <= d_grant_cnt_d;
    end
  end

  // Completion is steered to the owner with no added latency; a pmem_resp
  // outside a SERVE state reaches neither cache.
  assign i_mem_resp   = (state_q == SERVE_I) & pmem_resp;
  assign d_mem_resp   = (state_q == SERVE_D) & pmem_resp;
  assign i_mem_rdata  = pmem_rdata;
  assign d_mem_rdata  = pmem_rdata;

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign i_grant_cnt  = i_grant_cnt_q;
  assign d_grant_cnt  = d_grant_cnt_q;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench for lc3b_mem_arbiter. A transaction-level model of the
// arbiter is compared against the DUT on every falling edge; directed tests
// add hand-computed literal expectations. Counters are 3 bits wide here so
// saturation is reachable quickly.
module tb_lc3b_mem_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;
  localparam int CW = 3;
  localparam int CMAX = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [LW-1:0] i_mem_rdata;
  logic          i_mem_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_mem_rdata;
  logic          d_mem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;
  logic [CW-1:0] i_grant_cnt;
  logic [CW-1:0] d_grant_cnt;

  int checks = 0;
  int failures = 0;

  lc3b_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .i_mem_read(i_read), .i_mem_address(i_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_read(d_read), .d_mem_write(d_write), .d_mem_address(d_addr),
    .d_mem_wdata(d_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_owner: 0 = nobody, 1 = I-cache, 2 = D-cache. m_turn marks the idle
  // cycle after a completion. m_last_d: D was granted most recently.
  int          m_owner;
  bit          m_turn;
  bit          m_last_d;
  logic        m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  int          m_icnt, m_dcnt;

  // Model update: a grant happens only when nobody owns the port and the
  // post-completion cycle has passed.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner <= 0; m_turn <= 1'b0; m_last_d <= 1'b1;
      m_rd <= 1'b0; m_wr <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_icnt <= 0; m_dcnt <= 0;
    end else if (m_owner != 0) begin
      if (pmem_resp) begin
        m_owner <= 0; m_turn <= 1'b1; m_rd <= 1'b0; m_wr <= 1'b0;
      end
    end else if (m_turn) begin
      m_turn <= 1'b0;
    end else if (i_read && (!(d_read || d_write) || m_last_d)) begin
      m_owner <= 1; m_last_d <= 1'b0; m_rd <= 1'b1; m_wr <= 1'b0;
      m_addr <= i_addr;
      m_icnt <= (m_icnt < CMAX) ? m_icnt + 1 : CMAX;
    end else if (d_read || d_write) begin
      m_owner <= 2; m_last_d <= 1'b1; m_rd <= !d_write; m_wr <= d_write;
      m_addr <= d_addr; m_wdata <= d_wdata;
      m_dcnt <= (m_dcnt < CMAX) ? m_dcnt + 1 : CMAX;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("pmem_read",   pmem_read, m_rd);
    chk("pmem_write",  pmem_write, m_wr);
    chk("pmem_address", pmem_address, m_addr);
    chk("pmem_wdata",  pmem_wdata, m_wdata);
    chk("i_mem_resp",  i_mem_resp, (m_owner == 1) && pmem_resp);
    chk("d_mem_resp",  d_mem_resp, (m_owner == 2) && pmem_resp);
    chk("i_mem_rdata", i_mem_rdata, pmem_rdata);
    chk("d_mem_rdata", d_mem_rdata, pmem_rdata);
    chk("i_grant_cnt", i_grant_cnt, m_icnt);
    chk("d_grant_cnt", d_grant_cnt, m_dcnt);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Wait (bounded) for a memory command, hold it lat cycles, pulse pmem_resp,
  // then the owning cache drops its request.
  task automatic serve(input int lat, input logic [LW-1:0] rd, output int who);
    int n;
    n = 0;
    who = 0;
    while (!(pmem_read || pmem_write) && n < 40) begin
      cyc();
      n++;
    end
    if (!(pmem_read || pmem_write)) begin
      chk("serve_grant_timeout", 1'b0, 1'b1);
    end else begin
      who = m_owner;
      repeat (lat) cyc();
      pmem_resp = 1'b1;
      pmem_rdata = rd;
      cyc();
      pmem_resp = 1'b0;
      if (who == 1) i_read = 1'b0;
      else begin d_read = 1'b0; d_write = 1'b0; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int who;
    int order[6];
    logic [LW-1:0] a5;
    logic [LW-1:0] wpat;
    a5   = {16{8'hA5}};
    wpat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    // Test 1: single I read.
    do_reset();
    chk("t1_reset_read", pmem_read, 1'b0);
    chk("t1_reset_cnt", i_grant_cnt, 3'd0);
    i_read = 1'b1; i_addr = 16'h1230;
    chk("t1_no_cmd_yet", pmem_read, 1'b0);
    cyc();
    chk("t1_read_t1", pmem_read, 1'b1);
    chk("t1_addr", pmem_address, 16'h1230);
    repeat (3) cyc();
    pmem_resp = 1'b1; pmem_rdata = a5;
    #1;
    chk("t1_iresp", i_mem_resp, 1'b1);
    chk("t1_irdata", i_mem_rdata, a5);
    chk("t1_dresp", d_mem_resp, 1'b0);
    cyc();
    pmem_resp = 1'b0; i_read = 1'b0;
    #1;
    chk("t1_iresp_pulse", i_mem_resp, 1'b0);
    cyc();
    chk("t1_icnt", i_grant_cnt, 3'd1);

    // Test 2: simultaneous I read and D write out of reset.
    do_reset();
    i_read = 1'b1; i_addr = 16'h0040;
    d_write = 1'b1; d_addr = 16'h8000; d_wdata = wpat;
    serve(1, 128'h11, who);
    chk("t2_first_owner", who, 1);
    chk("t2_turn_idle", pmem_write, 1'b0);
    cyc();
    chk("t2_idle_nogrant", pmem_write, 1'b0);
    cyc();
    chk("t2_dwrite", pmem_write, 1'b1);
    chk("t2_daddr", pmem_address, 16'h8000);
    chk("t2_dwdata", pmem_wdata, wpat);
    serve(2, 128'h22, who);
    chk("t2_second_owner", who, 2);
    cyc();
    chk("t2_icnt", i_grant_cnt, 3'd1);
    chk("t2_dcnt", d_grant_cnt, 3'd1);

    // Test 3: both caches requesting continuously.
    do_reset();
    i_read = 1'b1; i_addr = 16'h0100;
    d_read = 1'b1; d_addr = 16'h0200;
    for (int k = 0; k < 6; k++) begin
      serve(k % 3, 128'h100 + LW'(k), who);
      order[k] = who;
      i_addr = i_addr + 16'h0002;
      d_addr = d_addr + 16'h0002;
      i_read = 1'b1; d_read = 1'b1;
    end
    for (int k = 0; k < 6; k++) begin
      chk("t3_order", order[k], (k % 2 == 0) ? 1 : 2);
    end
    i_read = 1'b0; d_read = 1'b0;
    repeat (3) cyc();

    // Test 4: D request arriving during SERVE_I.
    do_reset();
    i_read = 1'b1; i_addr = 16'h2000;
    cyc();
    chk("t4_igrant", pmem_read, 1'b1);
    d_read = 1'b1; d_addr = 16'h3000;
    cyc();
    d_addr = 16'h3002;
    cyc();
    chk("t4_addr_hold", pmem_address, 16'h2000);
    pmem_resp = 1'b1; pmem_rdata = 128'h44;
    cyc();
    pmem_resp = 1'b0; i_read = 1'b0;
    chk("t4_turn_nogrant", pmem_read, 1'b0);
    cyc();
    chk("t4_idle_nogrant", pmem_read, 1'b0);
    cyc();
    chk("t4_dgrant", pmem_read, 1'b1);
    chk("t4_daddr", pmem_address, 16'h3002);
    serve(1, 128'h55, who);
    chk("t4_owner", who, 2);
    cyc();

    // Test 5: reset in SERVE_D, then a stray pmem_resp while idle.
    do_reset();
    d_write = 1'b1; d_addr = 16'h4444; d_wdata = wpat;
    cyc();
    chk("t5_dwrite", pmem_write, 1'b1);
    cyc();
    #2 reset = 1'b1; pmem_resp = 1'b1;
    #1;
    chk("t5_rst_write", pmem_write, 1'b0);
    chk("t5_rst_dresp", d_mem_resp, 1'b0);
    chk("t5_rst_dcnt", d_grant_cnt, 3'd0);
    chk("t5_rst_addr", pmem_address, 16'h0000);
    d_write = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    cyc();
    chk("t5_idle_dresp", d_mem_resp, 1'b0);
    chk("t5_idle_iresp", i_mem_resp, 1'b0);
    chk("t5_idle_write", pmem_write, 1'b0);
    pmem_resp = 1'b0;
    cyc();

    // Test 6: I counter saturation.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      i_read = 1'b1; i_addr = 16'h0500 + 16'(k);
      serve(0, 128'h66, who);
      cyc();
      chk("t6_icnt", i_grant_cnt, (k + 1 < CMAX) ? k + 1 : CMAX);
    end
    chk("t6_sat", i_grant_cnt, 3'b111);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
